// File: rtl/zet_front_fetch_fifo.sv
// zet_front_fetch_fifo: show-ahead fetch queue between prefetch and decode
//   clk_i/rst_ni              : clock, asynchronous active-low reset
//   flush                     : discard all queued words (highest priority)
//   wr_fetch_fifo, fetch_dat_i,
//   fifo_cs_i, fifo_ip_i      : write strobe, word and its cs:ip tag
//   fifo_full                 : back-pressure to prefetch (level >= DEPTH-1)
//   q_rd_i                    : pop head entry
//   q_valid_o, q_dat_o,
//   q_cs_o, q_ip_o            : head entry, combinational from storage
//   q_level_o                 : number of stored entries, 0..DEPTH
//   ovf_o                     : sticky dropped-write flag, only with ZET_FETCH_FIFO_OVF_EN
module zet_front_fetch_fifo #(
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush,
    input  logic          wr_fetch_fifo,
    input  logic [15:0]   fetch_dat_i,
    input  logic [15:0]   fifo_cs_i,
    input  logic [15:0]   fifo_ip_i,
    output logic          fifo_full,
    input  logic          q_rd_i,
    output logic          q_valid_o,
    output logic [15:0]   q_dat_o,
    output logic [15:0]   q_cs_o,
    output logic [15:0]   q_ip_o,
    output logic [AW:0]   q_level_o,
    output logic          ovf_o
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_HI  = (AW+1)'(DEPTH - 1);
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          pop, push;
    assign q_valid_o = level != '0;
    assign pop       = q_rd_i && q_valid_o && !flush;
    // a full queue can still take a write when the head leaves in the same cycle
    assign push      = wr_fetch_fifo && !flush && (level != LVL_MAX || pop);
    // one entry of headroom: prefetch's registered strobe may land after full rises
    assign fifo_full = level >= LVL_HI;
    assign q_level_o = level;
    assign {q_cs_o, q_ip_o, q_dat_o} = q_valid_o ? mem[rd_ptr] : 48'h0;
    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= {fifo_cs_i, fifo_ip_i, fetch_dat_i};
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
`ifdef ZET_FETCH_FIFO_OVF_EN
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ovf_o <= 1'b0;
        else if (flush) ovf_o <= 1'b0;
        else if (wr_fetch_fifo && !push) ovf_o <= 1'b1;
`else
    assign ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_zet_front_fetch_fifo.sv
// tb_zet_front_fetch_fifo: scoreboard bench for zet_front_fetch_fifo
module tb_zet_front_fetch_fifo;
    localparam int AW = 3;
    localparam int DEPTH = 2 ** AW;
    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic          wr_fetch_fifo = 1'b0;
    logic [15:0]   fetch_dat_i = '0;
    logic [15:0]   fifo_cs_i = '0;
    logic [15:0]   fifo_ip_i = '0;
    logic          fifo_full;
    logic          q_rd_i = 1'b0;
    logic          q_valid_o;
    logic [15:0]   q_dat_o, q_cs_o, q_ip_o;
    logic [AW:0]   q_level_o;
    logic          ovf_o;
    logic [47:0]   mq[$];
    logic          movf = 1'b0;
    int            n_chk = 0, n_pass = 0;
`ifdef ZET_FETCH_FIFO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    zet_front_fetch_fifo #(.AW(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush(flush),
        .wr_fetch_fifo(wr_fetch_fifo), .fetch_dat_i(fetch_dat_i),
        .fifo_cs_i(fifo_cs_i), .fifo_ip_i(fifo_ip_i), .fifo_full(fifo_full),
        .q_rd_i(q_rd_i), .q_valid_o(q_valid_o), .q_dat_o(q_dat_o),
        .q_cs_o(q_cs_o), .q_ip_o(q_ip_o), .q_level_o(q_level_o), .ovf_o(ovf_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic check_state(input string tag);
        chk({tag, "_level"}, 48'(q_level_o), 48'(mq.size()));
        chk({tag, "_valid"}, 48'(q_valid_o), 48'(mq.size() != 0));
        chk({tag, "_full"}, 48'(fifo_full), 48'(mq.size() >= DEPTH - 1));
        chk({tag, "_ovf"}, 48'(ovf_o), 48'(movf && OVF_EN));
    endtask
    // one clock of stimulus; the model decides acceptance from its own queue
    task automatic step(input logic w, input logic [15:0] d, input logic [15:0] c,
                        input logic [15:0] i, input logic r, input logic f, input string tag);
        logic pop, push;
        logic [47:0] exp;
        wr_fetch_fifo = w; fetch_dat_i = d; fifo_cs_i = c; fifo_ip_i = i;
        q_rd_i = r; flush = f;
        #1;
        pop  = r && mq.size() != 0 && !f;
        push = w && !f && (mq.size() < DEPTH || pop);
        if (pop) begin
            exp = mq.pop_front();
            chk({tag, "_head"}, {q_cs_o, q_ip_o, q_dat_o}, exp);
        end
        if (f) begin
            mq.delete();
            movf = 1'b0;
        end else if (w && !push) movf = 1'b1;
        if (push) mq.push_back({c, i, d});
        @(posedge clk_i);
        #1;
        wr_fetch_fifo = 1'b0; q_rd_i = 1'b0; flush = 1'b0;
        check_state(tag);
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        #2;
        check_state("rst");
        chk("rst_dat", 48'(q_dat_o), 48'h0);
        #10 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step(1, 16'hB8C0, 16'hF000, 16'hFFF0, 0, 0, "single_wr");
        chk("single_dat", 48'(q_dat_o), 48'hB8C0);
        chk("single_cs", 48'(q_cs_o), 48'hF000);
        chk("single_ip", 48'(q_ip_o), 48'hFFF0);
        step(0, 0, 0, 0, 1, 0, "single_pop");
        for (int k = 0; k < 9; k++) step(1, 16'(k * 3 + 1), 16'h1000, 16'(k), 0, 0, "fill");
        chk("fill_ovf_kept", 48'(q_level_o), 48'(DEPTH));
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 0, "drain");
        step(1, 16'hEE, 16'h2000, 16'hFFFF, 0, 0, "empty_rd_ignored_pre");
        step(0, 0, 0, 0, 1, 0, "empty_rd_ignored_pop");
        step(0, 0, 0, 0, 1, 0, "empty_rd_ignored");
        for (int k = 0; k < 20; k++) step(1, 16'(k ^ 16'h5A5A), 16'h3000, 16'(k), k > 0, 0, "wrap");
        step(0, 0, 0, 0, 1, 0, "wrap_tail");
        for (int k = 0; k < 9; k++) step(1, 16'(k + 100), 16'h4000, 16'(k), 0, 0, "fill2");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, "to5");
        step(1, 16'hDEAD, 16'h5000, 16'h0077, 1, 1, "flush");
        chk("flush_dat", 48'(q_dat_o), 48'h0);
        step(1, 16'h1234, 16'h6000, 16'h0001, 1, 0, "empty_pop_wr");
        chk("empty_pop_wr_dat", 48'(q_dat_o), 48'h1234);
        step(0, 0, 0, 0, 1, 0, "empty_pop_wr_pop");
        for (int k = 0; k < 9; k++) step(1, 16'(k + 200), 16'h7000, 16'(k), 0, 0, "fill3");
        #2 rst_ni = 1'b0;
        mq.delete();
        movf = 1'b0;
        #1;
        check_state("async_rst");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(1, 16'hBEEF, 16'h8000, 16'h0002, 0, 0, "post_rst");
        step(0, 0, 0, 0, 1, 0, "post_rst_pop");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
